// File: rtl/alu_op_sequencer.sv
// Command sequencer: buffers ALU command words in an external register file,
// then replays them in order and hands each ALU result to a consumer.
module alu_op_sequencer #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [19:0]       cmd_data,
  input  logic              start,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [19:0]       rf_wr_data,
  input  logic [15:0]       alu_result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [15:0]       result_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CMD_W  = 20;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned LAT    = RD_LAT + ALU_LAT;
  localparam int unsigned WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                rf_wr_en_q, rf_wr_en_d;
  logic                rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [CMD_W-1:0]    rf_wr_data_q, rf_wr_data_d;
  logic                result_valid_q, result_valid_d;
  logic [RES_W-1:0]    result_data_q, result_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                cmd_hs;
  logic                last_cmd;

  assign cmd_ready    = cmd_ready_q;
  assign rf_wr_en     = rf_wr_en_q;
  assign rf_rd_en     = rf_rd_en_q;
  assign rf_addr      = rf_addr_q;
  assign rf_wr_data   = rf_wr_data_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    wait_cnt_d     = wait_cnt_q;
    cmd_ready_d    = 1'b0;
    rf_wr_en_d     = 1'b0;
    rf_rd_en_d     = 1'b0;
    rf_addr_d      = rf_addr_q;
    rf_wr_data_d   = rf_wr_data_q;
    result_valid_d = result_valid_q;
    result_data_d  = result_data_q;
    busy_d         = 1'b0;
    done_d         = 1'b0;

    cmd_hs   = cmd_valid & cmd_ready_q;
    last_cmd = ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1)));

    unique case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = wr_ptr_q;
          rf_wr_data_d = cmd_data;
          wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
          count_d      = count_q + CNT_W'(1);
        end
        if (start && ((count_q != '0) || cmd_hs)) begin
          state_d  = READ;
          rd_ptr_d = '0;
          // A same-cycle write owns the port first; the read follows next cycle
          if (!cmd_hs) begin
            rf_rd_en_d = 1'b1;
            rf_addr_d  = '0;
          end
        end
      end

      READ: begin
        if (rf_rd_en_q) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_W'(LAT - 1);
        end else begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = rd_ptr_q;
        end
      end

      WAIT: begin
        if (wait_cnt_q == '0) begin
          result_data_d  = alu_result;
          result_valid_d = 1'b1;
          state_d        = OUT;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      OUT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          if (last_cmd) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            state_d    = READ;
            rf_rd_en_d = 1'b1;
            rf_addr_d  = rd_ptr_q + ADDR_W'(1);
          end
        end
      end

      DONE: begin
        state_d  = IDLE;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE) && (count_d < CNT_W'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      wait_cnt_q     <= '0;
      cmd_ready_q    <= 1'b0;
      rf_wr_en_q     <= 1'b0;
      rf_rd_en_q     <= 1'b0;
      rf_addr_q      <= '0;
      rf_wr_data_q   <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      wait_cnt_q     <= wait_cnt_d;
      cmd_ready_q    <= cmd_ready_d;
      rf_wr_en_q     <= rf_wr_en_d;
      rf_rd_en_q     <= rf_rd_en_d;
      rf_addr_q      <= rf_addr_d;
      rf_wr_data_q   <= rf_wr_data_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: acts as register file + ALU and checks every cycle
// against a transaction-level model of the command/run/result behaviour.
module tb_alu_op_sequencer;

  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [19:0] cmd_data;
  logic        start;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [3:0]  rf_addr;
  logic [19:0] rf_wr_data;
  logic [15:0] alu_result;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] result_data;
  logic        busy;
  logic        done;

  alu_op_sequencer #(.ADDR_W(4), .RD_LAT(1), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .start(start),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .alu_result(alu_result),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
  } ent_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [19:0] mem [DEPTH];
  logic [19:0] exp_cmds [$];
  ent_t        exp_q [$];
  ent_t        alu_q [$];
  int          res_cyc [$];
  int          n_stored = 0;
  int          n_acc = 0;
  int          next_rd = 0;
  logic        running = 1'b0;
  logic        done_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference ALU: [19:16] function, [15:8] B, [7:0] A
  function automatic logic [15:0] alu_ref(input logic [19:0] w);
    logic [15:0] a;
    logic [15:0] b;
    a = {8'h00, w[7:0]};
    b = {8'h00, w[15:8]};
    case (w[19:16])
      4'h0:    return a & b;
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'h3:    return a * b;
      4'h4:    return a | b;
      4'h5:    return a ^ b;
      4'h6:    return a << 1;
      default: return {w[7:0], w[15:8]};
    endcase
  endfunction

  // One clock: capture pre-edge inputs, step the model, check outputs, drive the ALU
  task automatic tick();
    logic        hs, acc, st, rs, was_v, run_b, done_b;
    logic [19:0] cd;
    logic [15:0] held;
    ent_t        e;
    hs    = cmd_valid & cmd_ready;
    acc   = result_valid & result_ready;
    st    = start;
    rs    = rst;
    was_v = result_valid;
    cd    = cmd_data;
    held  = result_data;
    run_b = running;
    done_b = done_exp;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      running = 1'b0; n_stored = 0; n_acc = 0; next_rd = 0; done_exp = 1'b0;
      exp_q.delete(); alu_q.delete(); exp_cmds.delete();
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_wr_en", 32'(rf_wr_en), 0);
      chk("rst_rd_en", 32'(rf_rd_en), 0);
      chk("rst_addr", 32'(rf_addr), 0);
      chk("rst_wdata", 32'(rf_wr_data), 0);
      chk("rst_valid", 32'(result_valid), 0);
      chk("rst_data", 32'(result_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
    end else begin
      if (done_b) begin
        running = 1'b0; n_stored = 0; n_acc = 0; next_rd = 0; exp_cmds.delete();
      end
      done_exp = 1'b0;
      chk("wr_en", 32'(rf_wr_en), 32'(hs));
      if (hs) begin
        chk("wr_addr", 32'(rf_addr), 32'(n_stored));
        chk("wr_data", 32'(rf_wr_data), 32'(cd));
        mem[rf_addr] = rf_wr_data;
        exp_cmds.push_back(cd);
        n_stored++;
      end
      if (!run_b && st && (n_stored > 0)) running = 1'b1;
      if (acc) begin
        n_acc++;
        if (n_acc == n_stored) done_exp = 1'b1;
      end
      chk("rw_exclusive", 32'(rf_wr_en & rf_rd_en), 0);
      if (rf_rd_en) begin
        if (next_rd < exp_cmds.size() && running) begin
          chk("rd_addr", 32'(rf_addr), 32'(next_rd));
          e.due = cyc + LAT + 1; e.val = alu_ref(exp_cmds[next_rd]);
          exp_q.push_back(e);
          e.due = cyc + LAT; e.val = alu_ref(mem[rf_addr]);
          alu_q.push_back(e);
          next_rd++;
        end else begin
          chk("rd_unexpected", 32'(rf_rd_en), 0);
        end
      end
      if (result_valid && (!was_v || acc)) begin
        res_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("res_unexpected", 32'(result_valid), 0);
        end else begin
          chk("res_cycle", 32'(cyc), 32'(exp_q[0].due));
          chk("res_data", 32'(result_data), 32'(exp_q[0].val));
          exp_q.delete(0);
        end
      end else if (result_valid) begin
        chk("res_hold", 32'(result_data), 32'(held));
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("res_missing", 32'(result_valid), 1);
        exp_q.delete(0);
      end
      chk("done", 32'(done), 32'(done_exp));
      if (done) done_cnt++;
      chk("busy", 32'(busy), 32'(running));
      chk("cmd_ready", 32'(cmd_ready), 32'(!running && (n_stored < DEPTH)));
    end
    while (alu_q.size() > 0 && alu_q[0].due < cyc) alu_q.delete(0);
    if (alu_q.size() > 0 && alu_q[0].due == cyc) alu_result = alu_q[0].val;
    else if (alu_q.size() > 0)                    alu_result = ~alu_q[0].val;
    else                                           alu_result = 16'($urandom);
  endtask

  task automatic push_cmd(input logic [19:0] w, input logic with_start);
    cmd_valid = 1'b1; cmd_data = w; start = with_start;
    tick();
    cmd_valid = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Run until the model returns to idle, with random result backpressure
  task automatic drain(input int bp_pct);
    int budget;
    budget = 600;
    while (running && budget > 0) begin
      result_ready = ($urandom_range(99) >= 32'(bp_pct));
      tick();
      budget--;
    end
    result_ready = 1'b0;
    chk("drain_idle", 32'(busy), 0);
  endtask

  initial begin
    int          d0;
    int          k;
    int          n;
    logic [19:0] c0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; start = 1'b0;
    result_ready = 1'b0; alu_result = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 1);

    // start with nothing stored is ignored
    do_start();
    tick();
    chk("empty_start_busy", 32'(busy), 0);

    // single command, fixed values
    push_cmd(20'h10503, 1'b0);
    chk("t1_wr_en", 32'(rf_wr_en), 1);
    chk("t1_wr_addr", 32'(rf_addr), 0);
    chk("t1_wr_data", 32'(rf_wr_data), 32'h10503);
    do_start();
    chk("t1_rd_en", 32'(rf_rd_en), 1);
    tick(); tick(); tick();
    chk("t1_valid", 32'(result_valid), 1);
    chk("t1_data", 32'(result_data), 32'h0008);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("t1_done", 32'(done), 1);
    tick();
    chk("t1_busy", 32'(busy), 0);

    // start together with first command
    d0 = done_cnt;
    push_cmd(20'($urandom), 1'b1);
    drain(0);
    chk("t2_done_once", 32'(done_cnt - d0), 1);

    // fill all entries with cmd_valid held high; 17th word not written
    cmd_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      cmd_data = 20'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    chk("fill_ready_low", 32'(cmd_ready), 0);
    chk("fill_no_17th", 32'(rf_wr_en), 0);
    d0 = done_cnt;
    do_start();
    drain(30);
    chk("fill_done_once", 32'(done_cnt - d0), 1);

    // backpressure on the first of two results
    c0 = 20'($urandom);
    push_cmd(c0, 1'b0);
    push_cmd(20'($urandom), 1'b0);
    do_start();
    k = 0;
    while (!result_valid && k < 20) begin tick(); k++; end
    chk("bp_valid", 32'(result_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_hold", 32'(result_valid), 1);
      chk("bp_data_hold", 32'(result_data), 32'(alu_ref(c0)));
      chk("bp_no_read", 32'(rf_rd_en), 0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("bp_next_rd", 32'(rf_rd_en), 1);
    chk("bp_next_addr", 32'(rf_addr), 1);
    drain(0);

    // three commands, consumer always ready: results 4 cycles apart
    for (int i = 0; i < 3; i++) push_cmd(20'($urandom), 1'b0);
    res_cyc.delete();
    d0 = done_cnt;
    do_start();
    drain(0);
    chk("seq3_count", 32'(res_cyc.size()), 3);
    if (res_cyc.size() == 3) begin
      chk("seq3_gap1", 32'(res_cyc[1] - res_cyc[0]), 4);
      chk("seq3_gap2", 32'(res_cyc[2] - res_cyc[1]), 4);
    end
    chk("seq3_done_once", 32'(done_cnt - d0), 1);

    // reset during WAIT of the second command aborts the run
    for (int i = 0; i < 3; i++) push_cmd(20'($urandom), 1'b0);
    do_start();
    result_ready = 1'b1;
    k = 0;
    while (next_rd < 2 && k < 40) begin tick(); k++; end
    chk("abort_reached_cmd2", 32'(rf_rd_en), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    result_ready = 1'b0;
    d0 = done_cnt;
    do_start();
    chk("abort_start_ignored", 32'(busy), 0);
    for (int i = 0; i < 6; i++) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_no_valid", 32'(result_valid), 0);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) begin
        push_cmd(20'($urandom), (i == n - 1) && r[0]);
        if ($urandom_range(3) == 0) tick();
      end
      if (!running) do_start();
      d0 = done_cnt;
      drain(int'($urandom_range(0, 60)));
      chk("rand_done_once", 32'(done_cnt - d0), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register-file address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter RD_LAT, default 1, register-file read latency in cycles (at least 1).
REQ-003 SHALL have parameter ALU_LAT, default 1, ALU result latency in cycles (at least 1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  host command word valid.
REQ-007 SHALL have port cmd_ready  output  1  sequencer accepts a command word.
REQ-008 SHALL have port cmd_data  input  20  command word: [19:16] ALU function, [15:8] operand B, [7:0] operand A.
REQ-009 SHALL have port start  input  1  single-cycle request to execute the stored commands.
REQ-010 SHALL have port rf_wr_en  output  1  register-file write enable.
REQ-011 SHALL have port rf_rd_en  output  1  register-file read enable.
REQ-012 SHALL have port rf_addr  output  ADDR_W  register-file address.
REQ-013 SHALL have port rf_wr_data  output  20  register-file write data.
REQ-014 SHALL have port alu_result  input  16  ALU output, fed by the register-file read data.
REQ-015 SHALL have port result_valid  output  1  result_data holds a captured ALU result.
REQ-016 SHALL have port result_ready  input  1  consumer accepts result_data.
REQ-017 SHALL have port result_data  output  16  captured ALU result.
REQ-018 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-019 SHALL have port done  output  1  one-cycle pulse when a run completes.

Function
REQ-020 SHALL implement states IDLE, READ, WAIT, OUT and DONE, with all outputs driven from registers.
REQ-021 In IDLE, cmd_ready SHALL be 1 while count < 2^ADDR_W, and 0 when count equals 2^ADDR_W (full).
REQ-022 A handshake (cmd_valid and cmd_ready) SHALL write cmd_data to address wr_ptr in the following cycle (rf_wr_en=1, rf_addr=wr_ptr, rf_wr_data=cmd_data), then increment wr_ptr and count.
REQ-023 When full, cmd_valid SHALL be ignored, with no write and no counter change.
REQ-024 start in IDLE with count=0 SHALL be ignored.
REQ-025 start in IDLE with count>0 SHALL move the FSM to READ, with rd_ptr=0.
REQ-026 If start and a command handshake occur in the same cycle, the command SHALL be written first and SHALL be included in the run.
REQ-027 In READ, the sequencer SHALL drive rf_rd_en=1 and rf_addr=rd_ptr for exactly one cycle (cycle R), then go to WAIT.
REQ-028 In WAIT, the sequencer SHALL sample alu_result at the clock edge ending cycle R+RD_LAT+ALU_LAT, load it into result_data, set result_valid, and go to OUT.
REQ-029 In OUT, result_valid and result_data SHALL stay stable until result_ready=1; result_valid SHALL clear on the accepting edge.
REQ-030 On acceptance in OUT: if rd_ptr = count-1, the FSM SHALL go to DONE; otherwise rd_ptr SHALL increment and the FSM SHALL go to READ.
REQ-031 In DONE, the sequencer SHALL pulse done=1 for one cycle, clear wr_ptr, rd_ptr and count to 0, and return to IDLE.
REQ-032 cmd_ready SHALL be 0 and start SHALL be ignored in every state other than IDLE.
REQ-033 rf_wr_en and rf_rd_en SHALL never both be 1 in the same cycle.
REQ-034 A full run of 2^ADDR_W commands SHALL wrap rd_ptr only via the DONE clear, with no aliasing of address 0.
REQ-035 Per-command throughput SHALL be 1 (READ) + RD_LAT+ALU_LAT (WAIT) + at least 1 (OUT) cycles.

Reset
REQ-036 While rst=1 at a clock edge, the FSM SHALL enter IDLE and wr_ptr, rd_ptr and count SHALL clear.
REQ-037 Reset values SHALL be cmd_ready=0, rf_wr_en=0, rf_rd_en=0, rf_addr=0, rf_wr_data=0, result_valid=0, result_data=0, busy=0, done=0; cmd_ready SHALL become 1 in the first cycle after rst deasserts.
REQ-038 Reset during a run SHALL abort it: no further result_valid and no done pulse, and stored commands SHALL be discarded (count=0).

Verification
REQ-039 Load one command and run: cmd_data=0x10503 -> rf_wr_en=1, rf_addr=0, rf_wr_data=0x10503; start -> rf_rd_en at cycle R; bench drives alu_result=0x0008 -> result_valid=1 with result_data=0x0008 at cycle R+3 (defaults); result_ready=1 -> done pulse, busy=0.
REQ-040 Fill all 16 entries with cmd_valid held high -> writes at addresses 0..15, cmd_ready=0 after the 16th handshake; a 17th word is not written.
REQ-041 Backpressure: hold result_ready=0 for 5 cycles -> result_valid and result_data are stable and no rf_rd_en occurs; release -> next READ at rd_ptr+1.
REQ-042 start with count=0 -> no state change, busy stays 0; start together with the first cmd_valid -> a run of one command.
REQ-043 Assert rst during WAIT of command 2 of 3 -> all outputs reach their reset values the next cycle, no done pulse, and a new start with count=0 is ignored.
REQ-044 A sequence of 3 commands with result_ready always 1 -> 3 results in address order, each 4 cycles apart (defaults), and done once.
